// File: rtl/dbf_line_seq_if.sv
// Bundle of line-sequencer control, configuration and channel-control signals.
// The master side drives triggers and timing configuration. The slave side
// (the sequencer) drives the shared channel controls and status.
interface dbf_line_seq_if #(
    parameter int ADDR_WD = 8,
    parameter int CNT_WD  = 16,
    parameter int LINE_WD = 8
);
    logic               line_trig;
    logic               abort;
    logic [CNT_WD-1:0]  tx_len;
    logic [CNT_WD-1:0]  rx_dly;
    logic [CNT_WD-1:0]  rx_len;
    logic [CNT_WD-1:0]  zone_len;
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               busy;
    logic               line_done;
    logic               trig_miss;
    logic [LINE_WD-1:0] line_cnt;

    modport master (
        output line_trig, abort, tx_len, rx_dly, rx_len, zone_len,
        input  tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done,
               trig_miss, line_cnt
    );

    modport slave (
        input  line_trig, abort, tx_len, rx_dly, rx_len, zone_len,
        output tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done,
               trig_miss, line_cnt
    );
endinterface

// File: rtl/dbf_line_seq.sv
// Scan-line sequencer. It runs TX, dead time, RX and DONE for each triggered
// line. During RX it walks the focus-zone LUT address. All outputs are
// registered from the next-state decode, so they line up with the state
// register.
module dbf_line_seq #(
    parameter int ADDR_WD   = 8,
    parameter int CNT_WD    = 16,
    parameter int LINE_WD   = 8,
    parameter int NUM_LINES = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    dbf_line_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

    localparam logic [ADDR_WD-1:0] ADDR_MAX = {ADDR_WD{1'b1}};
    localparam logic [LINE_WD-1:0] LINE_LAST = LINE_WD'(NUM_LINES - 1);
    localparam logic [CNT_WD-1:0]  ONE = CNT_WD'(1);

    state_t             state, state_nxt;
    logic [CNT_WD-1:0]  cnt, cnt_nxt;
    logic [CNT_WD-1:0]  zone_cnt, zone_nxt;
    logic [CNT_WD-1:0]  sh_dly, sh_rx, sh_zone;
    logic [ADDR_WD-1:0] addr_nxt;
    logic               we_nxt;
    logic               cfg_load;

    // A zero length would otherwise underflow the down-counters; run it as 1.
    function automatic logic [CNT_WD-1:0] eff(input logic [CNT_WD-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // Next-state, phase counter and zone walker decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        zone_nxt  = zone_cnt;
        addr_nxt  = bus.dbf_lut_addr;
        we_nxt    = 1'b0;
        cfg_load  = 1'b0;

        case (state)
            S_IDLE: if (bus.line_trig) begin
                state_nxt = S_TX;
                cnt_nxt   = eff(bus.tx_len) - ONE;
            end
            S_TX: if (cnt == '0) begin
                state_nxt = S_WAIT;
                cnt_nxt   = sh_dly - ONE;
            end else cnt_nxt = cnt - ONE;
            S_WAIT: if (cnt == '0) begin
                state_nxt = S_RX;
                cnt_nxt   = sh_rx - ONE;
            end else cnt_nxt = cnt - ONE;
            S_RX: if (cnt == '0) state_nxt = S_DONE;
                  else cnt_nxt = cnt - ONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (bus.abort) state_nxt = S_IDLE;

        cfg_load = (state == S_IDLE) && (state_nxt == S_TX);

        // The zone address is 0 on RX entry and at IDLE. It holds through DONE.
        if (state_nxt == S_IDLE) begin
            addr_nxt = '0;
        end else if (state_nxt == S_RX && state != S_RX) begin
            addr_nxt = '0;
            we_nxt   = 1'b1;
            zone_nxt = sh_zone - ONE;
        end else if (state_nxt == S_RX) begin
            if (zone_cnt == '0) begin
                zone_nxt = sh_zone - ONE;
                if (bus.dbf_lut_addr != ADDR_MAX) begin
                    addr_nxt = bus.dbf_lut_addr + 1'b1;
                    we_nxt   = 1'b1;
                end
            end else begin
                zone_nxt = zone_cnt - ONE;
            end
        end
    end

    // State, counters and the per-line configuration shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            zone_cnt <= '0;
            sh_dly   <= ONE;
            sh_rx    <= ONE;
            sh_zone  <= ONE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            zone_cnt <= zone_nxt;
            if (cfg_load) begin
                sh_dly  <= eff(bus.rx_dly);
                sh_rx   <= eff(bus.rx_len);
                sh_zone <= eff(bus.zone_len);
            end
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_en        <= 1'b0;
            bus.start        <= 1'b0;
            bus.dbf_lut_addr <= '0;
            bus.dbf_lut_we   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.line_done    <= 1'b0;
            bus.trig_miss    <= 1'b0;
            bus.line_cnt     <= '0;
        end else begin
            bus.tx_en        <= (state_nxt == S_TX);
            bus.start        <= (state_nxt == S_RX);
            bus.dbf_lut_addr <= addr_nxt;
            bus.dbf_lut_we   <= we_nxt;
            bus.busy         <= (state_nxt != S_IDLE);
            bus.line_done    <= (state_nxt == S_DONE);
            bus.trig_miss    <= bus.line_trig && (state != S_IDLE);
            if (state_nxt == S_DONE && state != S_DONE)
                bus.line_cnt <= (bus.line_cnt == LINE_LAST) ? '0 : bus.line_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dbf_line_seq.sv
// Bench for dbf_line_seq (ADDR_WD=2, NUM_LINES=4). Each line is compared
// cycle by cycle against an arithmetic model of the expected line waveform.
module tb_dbf_line_seq;
    localparam int ADDR_WD = 2;
    localparam int CNT_WD  = 16;
    localparam int LINE_WD = 8;
    localparam int NLINES  = 4;
    localparam int AMAX    = (1 << ADDR_WD) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    dbf_line_seq_if #(.ADDR_WD(ADDR_WD), .CNT_WD(CNT_WD), .LINE_WD(LINE_WD)) bus ();

    dbf_line_seq #(.ADDR_WD(ADDR_WD), .CNT_WD(CNT_WD), .LINE_WD(LINE_WD),
                   .NUM_LINES(NLINES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Output vector: {tx_en,start,we,line_done,busy,trig_miss,addr}
    function automatic logic [5+ADDR_WD:0] obs();
        return {bus.tx_en, bus.start, bus.dbf_lut_we, bus.line_done, bus.busy,
                bus.trig_miss, bus.dbf_lut_addr};
    endfunction

    // Trigger one line and check every cycle from the sampling edge until IDLE.
    // Returns at a negedge with the DUT idle, so a new trigger can follow at once.
    task automatic run_line(input int t, input int d, input int r, input int z,
                            input int miss_at, input int abort_at);
        int te, de, re, ze, l, rel, zi, a;
        logic [5+ADDR_WD:0] exp;
        logic e_tx, e_st, e_we, e_dn, e_bz, e_ms;
        te = eff(t); de = eff(d); re = eff(r); ze = eff(z);
        l  = te + de + re;
        bus.tx_len = CNT_WD'(t); bus.rx_dly = CNT_WD'(d);
        bus.rx_len = CNT_WD'(r); bus.zone_len = CNT_WD'(z);
        bus.line_trig = 1'b1;
        @(posedge clk);
        #1;
        bus.line_trig = 1'b0;
        // Scramble config: the latched copy must govern this line.
        bus.tx_len = CNT_WD'($urandom_range(0, 9)); bus.rx_dly = CNT_WD'($urandom_range(0, 9));
        bus.rx_len = CNT_WD'($urandom_range(0, 9)); bus.zone_len = CNT_WD'($urandom_range(0, 9));
        for (int k = 0; k <= l + 1; k++) begin
            @(negedge clk);
            if (abort_at >= 0 && k == abort_at + 1) begin
                bus.abort = 1'b0;
                checks++;
                if (obs() !== '0) begin
                    errors++;
                    $display("FAIL abort_outputs k=%0d got=%b exp=%b", k, obs(), '0);
                end
                checks++;
                if (bus.line_cnt !== LINE_WD'(exp_cnt)) begin
                    errors++;
                    $display("FAIL abort_line_cnt got=%0d exp=%0d", bus.line_cnt, exp_cnt);
                end
                return;
            end
            e_tx = (k < te);
            e_st = (k >= te + de) && (k < l);
            e_dn = (k == l);
            e_bz = (k <= l);
            e_ms = (miss_at >= 0) && (k == miss_at + 1);
            e_we = 1'b0;
            a    = 0;
            if (e_st) begin
                rel = k - (te + de);
                zi  = rel / ze;
                a   = (zi > AMAX) ? AMAX : zi;
                e_we = (rel % ze == 0) && (zi <= AMAX);
            end else if (e_dn) begin
                zi = (re - 1) / ze;
                a  = (zi > AMAX) ? AMAX : zi;
            end
            exp = {e_tx, e_st, e_we, e_dn, e_bz, e_ms, ADDR_WD'(a)};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL line_outputs t=%0d d=%0d r=%0d z=%0d k=%0d got=%b exp=%b",
                         t, d, r, z, k, obs(), exp);
            end
            if (k == l + 1) begin
                exp_cnt = (exp_cnt + 1) % NLINES;
                checks++;
                if (bus.line_cnt !== LINE_WD'(exp_cnt)) begin
                    errors++;
                    $display("FAIL line_cnt got=%0d exp=%0d", bus.line_cnt, exp_cnt);
                end
            end else begin
                bus.line_trig = (k == miss_at);
                bus.abort     = (k == abort_at);
            end
        end
        bus.line_trig = 1'b0;
    endtask

    task automatic test_reset();
        bus.line_trig = 1'b0; bus.abort = 1'b0;
        bus.tx_len = '0; bus.rx_dly = '0; bus.rx_len = '0; bus.zone_len = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs() !== '0 || bus.line_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b cnt=%0d exp=0", obs(), bus.line_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < NLINES; i++) run_line(1, 1, 2, 1, -1, -1);
    endtask

    task automatic test_basic();
        run_line(3, 2, 10, 4, -1, -1);
    endtask

    task automatic test_zero_cfg();
        run_line(0, 0, 0, 0, -1, -1);
    endtask

    task automatic test_saturation();
        run_line(1, 1, 6, 1, -1, -1);
    endtask

    task automatic test_busy_trigger();
        run_line(2, 1, 5, 2, 5, -1);
        run_line(2, 2, 3, 1, -1, -1);
    endtask

    task automatic test_abort();
        run_line(2, 1, 6, 2, -1, 5);
        run_line(2, 1, 4, 2, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int t, d, r, z, m;
            t = $urandom_range(0, 6); d = $urandom_range(0, 6);
            r = $urandom_range(0, 12); z = $urandom_range(0, 4);
            m = ($urandom_range(0, 2) == 0) ?
                $urandom_range(0, eff(t) + eff(d) + eff(r)) : -1;
            run_line(t, d, r, z, m, -1);
        end
    endtask

    task automatic test_reset_mid_tx();
        bus.tx_len = CNT_WD'(10); bus.rx_dly = CNT_WD'(1);
        bus.rx_len = CNT_WD'(1); bus.zone_len = CNT_WD'(1);
        bus.line_trig = 1'b1;
        @(posedge clk);
        #1;
        bus.line_trig = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_tx_tx_en got=%b exp=1", bus.tx_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== '0 || bus.line_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b cnt=%0d exp=0", obs(), bus.line_cnt);
        end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_line(2, 1, 3, 1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_basic();
        test_zero_cfg();
        test_saturation();
        test_busy_trigger();
        test_abort();
        test_random();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbf_line_seq.md
# dbf_line_seq

Scan-line sequencer for the digital beamformer. It generates the per-line `tx_en` transmit window, the receive dead time, and the `start` receive window for every `dbf_ch*` channel. During the receive window it steps `dbf_lut_addr` through the dynamic-focus zones of the channel coarse/fine delay LUTs and strobes `dbf_lut_we` at each zone boundary. It sits above the channel array and is the single driver of those shared channel control inputs.

## Interface
Parameters:
- `ADDR_WD`, 8: width of `dbf_lut_addr`; must match the channel LUT address width.
- `CNT_WD`, 16: width of the timing configuration counters.
- `LINE_WD`, 8: width of the line counter.
- `NUM_LINES`, 128: lines per frame; `line_cnt` wraps after `NUM_LINES-1`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `line_trig`  in  1  start-of-line request, sampled only in IDLE.
- `abort`  in  1  synchronous abort; highest priority after reset.
- `tx_len`  in  CNT_WD  transmit window length in cycles.
- `rx_dly`  in  CNT_WD  dead time between TX and RX in cycles.
- `rx_len`  in  CNT_WD  receive window length in cycles.
- `zone_len`  in  CNT_WD  cycles per focus zone.
- `tx_en`  out  1  transmit window to channels.
- `start`  out  1  receive window to channels.
- `dbf_lut_addr`  out  ADDR_WD  current focus-zone LUT address.
- `dbf_lut_we`  out  1  one-cycle zone-load strobe.
- `busy`  out  1  high in every state except IDLE.
- `line_done`  out  1  one-cycle pulse at the end of a line.
- `trig_miss`  out  1  one-cycle pulse when `line_trig` arrives while busy.
- `line_cnt`  out  LINE_WD  index of the current or most recently completed line.

## Operation
- FSM states: IDLE → TX → WAIT → RX → DONE → IDLE.
- IDLE:
  - `line_trig`=1 latches `tx_len`, `rx_dly`, `rx_len` and `zone_len` into shadow registers and moves to TX.
  - Input changes after the latch do not affect the current line.
- Zero-valued configuration: `tx_len`, `rx_dly`, `rx_len` and `zone_len` values of 0 are treated as 1. No state is ever skipped.
- TX: stays `tx_len` cycles, then goes to WAIT.
- WAIT: stays `rx_dly` cycles, then goes to RX.
- RX: stays `rx_len` cycles, then goes to DONE.
  - On the first RX cycle, `dbf_lut_addr`=0 and `dbf_lut_we`=1.
  - Every `zone_len` cycles after that, `dbf_lut_addr` increments and `dbf_lut_we` pulses.
  - `dbf_lut_addr` saturates at 2^ADDR_WD−1. Once saturated, no further `dbf_lut_we` pulses occur.
- DONE:
  - Lasts 1 cycle with `line_done`=1.
  - `line_cnt` increments, wrapping from NUM_LINES−1 to 0.
  - Then returns to IDLE.
- Outputs are registered and decoded from state: `tx_en`=1 only in TX, `start`=1 only in RX.
- `trig_miss` pulses for any `line_trig`=1 sampled outside IDLE. That trigger is dropped.
- `abort`=1 in any state:
  - Next state is IDLE.
  - `tx_en`, `start`, `dbf_lut_we` and `line_done` are low the following cycle.
  - `line_cnt` is not incremented and `dbf_lut_addr` returns to 0.
  - `abort` with `line_trig` in IDLE: abort wins and no line starts.
- `dbf_lut_addr` holds its last value from the end of RX until IDLE is entered, then reads 0.

## Timing
- Reset values: state IDLE; all 1-bit outputs 0; `dbf_lut_addr`=0; `line_cnt`=0.
- Reset mid-line forces these values immediately, asynchronously.
- `line_trig` high at edge N: `tx_en` and `busy` are high from edge N through edge N+`tx_len`, i.e. exactly `tx_len` cycles starting the cycle after the trigger is sampled.
- The first `start` cycle follows the last `tx_en` cycle by `rx_dly` cycles. `start` lasts exactly `rx_len` cycles.
- `line_done` occurs in the cycle immediately after the last `start` cycle.
- Trigger to `line_done`: `tx_len`+`rx_dly`+`rx_len`+1 cycles.
- `busy` drops the cycle after `line_done`. A `line_trig` in that same cycle is accepted.
- `dbf_lut_we` is asserted in the same cycle that the new `dbf_lut_addr` value first appears.

## Test plan
- Basic line: `tx_len`=3, `rx_dly`=2, `rx_len`=10, `zone_len`=4 → `tx_en` 3 cycles, 2 idle cycles, `start` 10 cycles; `dbf_lut_addr` reads 0,0,0,0,1,1,1,1,2,2; `dbf_lut_we` at RX cycles 0, 4 and 8; `line_done` 16 cycles after the trigger; `line_cnt`=1.
- Zero config: all four configuration values = 0 → `tx_en` 1 cycle, dead time 1 cycle, `start` 1 cycle, `line_done` at trigger+4.
- Saturation (ADDR_WD=2): `zone_len`=1, `rx_len`=6 → `dbf_lut_addr` reads 0,1,2,3,3,3; `dbf_lut_we` asserted only in the first 4 RX cycles.
- Busy trigger: `line_trig` pulsed mid-RX → one `trig_miss` pulse; line timing unchanged. A trigger in the cycle after `line_done` starts the next line.
- Abort: `abort` in the 3rd RX cycle → all outputs low next cycle, `line_done` never pulses, `line_cnt` unchanged. A new trigger then runs a normal line.
- Wrap and reset: run NUM_LINES=4 lines → `line_cnt` reads 1,2,3,0. Drop `rst_n` mid-TX → `tx_en` falls immediately and the block restarts in IDLE.
